// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
//   Shared widths, types and arithmetic helpers for the Sobel edge path.
//   PIX_W   : pixel width (unsigned)
//   GRAD_W  : signed gradient width, holds +/-1020
//   MAG_W   : unsigned |Gx|+|Gy| width, holds up to 2040
//   PIX_MAX : saturation ceiling for the magnitude output
// -----------------------------------------------------------------------------
package sobel_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned GRAD_W = 11;
    localparam int unsigned MAG_W  = 11;

    typedef logic        [PIX_W-1:0]  pixel_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic        [MAG_W-1:0]  mag_t;

    // win[i][j]: i=0 top (oldest line) .. 2 bottom (current line),
    //            j=0 oldest column .. 2 newest column
    typedef logic [2:0][2:0][PIX_W-1:0] window_t;

    localparam pixel_t PIX_MAX = '1;

    // Zero-extend an unsigned pixel into the signed gradient domain.
    function automatic grad_t widen(input pixel_t p);
        return signed'({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

    // Gradient magnitude never reaches -1024, so negation cannot overflow.
    function automatic mag_t absMag(input grad_t g);
        grad_t n;
        n = -g;
        return g[GRAD_W-1] ? mag_t'(n) : mag_t'(g);
    endfunction

    function automatic pixel_t saturate(input mag_t m);
        return (m > mag_t'(PIX_MAX)) ? PIX_MAX : m[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_gradient_core.sv
// -----------------------------------------------------------------------------
// sobel_gradient_core
//   Pipeline stages 2 and 3 of the Sobel path. Stage 2 registers the signed
//   Gx/Gy gradients of the 3x3 window; stage 3 registers the saturated
//   |Gx|+|Gy| magnitude and its threshold bit. Runs every clock; validity is
//   carried alongside the data.
//   Ports:
//     CLK, RSTn    clock, asynchronous active-low reset
//     Window       3x3 pixel window from stage 1
//     V1, F1       stage-1 valid / last-pixel-of-frame flags
//     DataOut      min(|Gx|+|Gy|, 255), held while ValidOut=0
//     EdgeBin      DataOut >= THRESH, held while ValidOut=0
//     ValidOut     outputs meaningful this cycle
//     FrameDone    one-cycle pulse with the frame's final valid output
// -----------------------------------------------------------------------------
module sobel_gradient_core
    import sobel_pkg::*;
#(
    parameter int unsigned THRESH = 64
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  window_t          Window,
    input  logic             V1,
    input  logic             F1,
    output logic [PIX_W-1:0] DataOut,
    output logic             EdgeBin,
    output logic             ValidOut,
    output logic             FrameDone
);

    localparam mag_t THR = mag_t'(THRESH);

    grad_t  gxNext;
    grad_t  gyNext;
    grad_t  gx;
    grad_t  gy;
    logic   v2;
    logic   f2;
    mag_t   magNext;
    pixel_t satNext;

    // Stage 2 combinational gradients
    always_comb begin
        gxNext = (widen(Window[0][2]) + (widen(Window[1][2]) <<< 1) + widen(Window[2][2]))
               - (widen(Window[0][0]) + (widen(Window[1][0]) <<< 1) + widen(Window[2][0]));
        gyNext = (widen(Window[2][0]) + (widen(Window[2][1]) <<< 1) + widen(Window[2][2]))
               - (widen(Window[0][0]) + (widen(Window[0][1]) <<< 1) + widen(Window[0][2]));
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            gx <= '0;
            gy <= '0;
            v2 <= 1'b0;
            f2 <= 1'b0;
        end else begin
            v2 <= V1;
            f2 <= F1;
            if (V1) begin
                gx <= gxNext;
                gy <= gyNext;
            end
        end
    end

    // Stage 3 combinational magnitude and saturation
    always_comb begin
        magNext = absMag(gx) + absMag(gy);
        satNext = saturate(magNext);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            DataOut   <= '0;
            EdgeBin   <= 1'b0;
            ValidOut  <= 1'b0;
            FrameDone <= 1'b0;
        end else begin
            ValidOut  <= v2;
            FrameDone <= f2;
            if (v2) begin
                DataOut <= satNext;
                EdgeBin <= (mag_t'(satNext) >= THR);
            end
        end
    end

endmodule

// File: rtl/sobel_window_gradient.sv
// -----------------------------------------------------------------------------
// sobel_window_gradient
//   Consumer of the line-buffer FIFO chain. Assembles a 3x3 window from three
//   vertically aligned taps, tracks the incoming pixel position and flags only
//   windows fully inside the frame, then hands the window to the gradient core.
//   Latency: pixel accepted on edge k -> ValidOut high after edge k+2.
//   Ports:
//     CLK        rising-edge clock
//     RSTn       asynchronous active-low reset
//     Enable     pixel strobe (shared with the line-buffer FIFOs)
//     Row0       pixel (r,c), current line
//     Row1       pixel (r-1,c)
//     Row2       pixel (r-2,c)
//     DataOut    min(|Gx|+|Gy|,255) for the window centred at (r-1,c-1)
//     EdgeBin    DataOut >= THRESH
//     ValidOut   DataOut/EdgeBin/FrameDone meaningful this cycle
//     FrameDone  one-cycle pulse with the frame's last valid output
// -----------------------------------------------------------------------------
module sobel_window_gradient
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 16,
    parameter int unsigned IMG_HEIGHT = 16,
    parameter int unsigned THRESH     = 64
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Enable,
    input  logic [PIX_W-1:0] Row0,
    input  logic [PIX_W-1:0] Row1,
    input  logic [PIX_W-1:0] Row2,
    output logic [PIX_W-1:0] DataOut,
    output logic             EdgeBin,
    output logic             ValidOut,
    output logic             FrameDone
);

    localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    window_t          win;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             colLast;
    logic             rowLast;
    logic             winValid;
    logic             lastPix;
    logic             v1;
    logic             f1;

    // Position decode on the pre-increment counters: the first two columns
    // and rows never have a complete window behind them.
    always_comb begin
        colLast  = (col == COL_LAST);
        rowLast  = (row == ROW_LAST);
        winValid = Enable && (col >= COL_W'(2)) && (row >= ROW_W'(2));
        lastPix  = colLast && rowLast;
    end

    // Window shift: newest column enters at j=2
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            win <= '0;
        end else if (Enable) begin
            for (int unsigned i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= Row2;
            win[1][2] <= Row1;
            win[2][2] <= Row0;
        end
    end

    // Column/row position of the incoming pixel
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            col <= '0;
            row <= '0;
        end else if (Enable) begin
            if (colLast) begin
                col <= '0;
                row <= rowLast ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Stage 1 flags, aligned with the window they describe
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            v1 <= 1'b0;
            f1 <= 1'b0;
        end else begin
            v1 <= winValid;
            f1 <= winValid && lastPix;
        end
    end

    sobel_gradient_core #(
        .THRESH (THRESH)
    ) uCore (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Window    (win),
        .V1        (v1),
        .F1        (f1),
        .DataOut   (DataOut),
        .EdgeBin   (EdgeBin),
        .ValidOut  (ValidOut),
        .FrameDone (FrameDone)
    );

endmodule

// File: tb/tb_sobel_window_gradient.sv
module tb_sobel_window_gradient;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       Enable;
    logic [7:0] Row0;
    logic [7:0] Row1;
    logic [7:0] Row2;
    logic [7:0] DataOut;
    logic       EdgeBin;
    logic       ValidOut;
    logic       FrameDone;

    sobel_window_gradient #(
        .IMG_WIDTH  (16),
        .IMG_HEIGHT (16),
        .THRESH     (64)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Enable    (Enable),
        .Row0      (Row0),
        .Row1      (Row1),
        .Row2      (Row2),
        .DataOut   (DataOut),
        .EdgeBin   (EdgeBin),
        .ValidOut  (ValidOut),
        .FrameDone (FrameDone)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks     = 0;
    int errors     = 0;
    int validCount = 0;
    int fdCount    = 0;

    typedef enum int {K_FLAT, K_ROWS, K_VSTEP, K_HSTEP, K_RAMP8, K_RAMP7, K_NRAMP} kind_e;

    typedef struct {
        string name;
        kind_e kind;
        bit    toggle;
        int    expValid;
        int    expFd;
    } vec_t;

    typedef struct {
        int cyc;
        int data;
        bit edgeBit;
        bit fd;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int img(input kind_e k, input int r, input int c);
        if (r < 0) return 0;
        case (k)
            K_VSTEP: return (c >= 8) ? 255 : 0;
            K_HSTEP: return (r >= 8) ? 255 : 0;
            K_RAMP8: return 8 * c;
            K_RAMP7: return 7 * c;
            K_NRAMP: return 255 - 8 * c;
            default: return 0;
        endcase
    endfunction

    // Hand-derived saturated magnitude for the window completed by pixel (r,c)
    function automatic int expMag(input kind_e k, input int r, input int c);
        case (k)
            K_FLAT:  return 0;
            K_ROWS:  return 80;                              // Gy = 120 - 40
            K_VSTEP: return (c == 8 || c == 9) ? 255 : 0;    // Gx = 1020 across the step
            K_HSTEP: return (r == 8 || r == 9) ? 255 : 0;    // Gy = 1020 across the step
            K_RAMP8: return 64;                              // Gx = 4*16
            K_RAMP7: return 56;                              // Gx = 4*14
            K_NRAMP: return 64;                              // Gx = -64
            default: return -1;
        endcase
    endfunction

    task automatic setTaps(input kind_e k, input int r, input int c);
        if (k == K_FLAT) begin
            Row0 = 8'd100; Row1 = 8'd100; Row2 = 8'd100;
        end else if (k == K_ROWS) begin
            Row0 = 8'd30; Row1 = 8'd20; Row2 = 8'd10;
        end else begin
            Row0 = 8'(img(k, r, c));
            Row1 = 8'(img(k, r - 1, c));
            Row2 = 8'(img(k, r - 2, c));
        end
    endtask

    task automatic sendPixel(input kind_e k, input int r, input int c, input bit toggle);
        exp_t e;
        setTaps(k, r, c);
        Enable = 1'b1;
        if (r >= 2 && c >= 2) begin
            e.cyc     = cyc + 3;
            e.data    = expMag(k, r, c);
            e.edgeBit = (e.data >= 64);
            e.fd      = (r == 15 && c == 15);
            sbq.push_back(e);
        end
        @(posedge CLK); #1;
        if (toggle) begin
            Enable = 1'b0;
            Row0 = 8'($urandom);
            Row1 = 8'($urandom);
            Row2 = 8'($urandom);
            @(posedge CLK); #1;
        end
    endtask

    task automatic sendFrame(input kind_e k, input bit toggle);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                sendPixel(k, r, c, toggle);
    endtask

    task automatic idle(input int n);
        Enable = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic checkFrame(input string name, input int expV, input int expFd);
        idle(4);
        chk({name, "_valid_count"}, validCount, expV);
        chk({name, "_framedone_count"}, fdCount, expFd);
        chk({name, "_sb_left"}, sbq.size(), 0);
        validCount = 0;
        fdCount    = 0;
        sbq.delete();
    endtask

    task automatic checkOutputsZero(input string name);
        chk({name, "_DataOut"}, DataOut, 0);
        chk({name, "_EdgeBin"}, EdgeBin, 0);
        chk({name, "_ValidOut"}, ValidOut, 0);
        chk({name, "_FrameDone"}, FrameDone, 0);
    endtask

    // Output monitor: every valid must match the oldest pending expectation
    always @(negedge CLK) begin
        exp_t e;
        if (ValidOut) begin
            validCount++;
            if (FrameDone) fdCount++;
            if (sbq.size() == 0) begin
                chk("spurious_valid", int'(ValidOut), 0);
            end else begin
                e = sbq.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("data_out", DataOut, e.data);
                chk("edge_bin", EdgeBin, e.edgeBit);
                chk("frame_done", FrameDone, e.fd);
            end
        end else begin
            chk("framedone_without_valid", FrameDone, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vecs[0] = '{"flat",         K_FLAT,  1'b0, 196, 1};
        vecs[1] = '{"rows",         K_ROWS,  1'b0, 196, 1};
        vecs[2] = '{"vstep",        K_VSTEP, 1'b0, 196, 1};
        vecs[3] = '{"vstep_toggle", K_VSTEP, 1'b1, 196, 1};
        vecs[4] = '{"flat_toggle",  K_FLAT,  1'b1, 196, 1};
        vecs[5] = '{"hstep",        K_HSTEP, 1'b0, 196, 1};
        vecs[6] = '{"ramp8",        K_RAMP8, 1'b0, 196, 1};
        vecs[7] = '{"ramp7",        K_RAMP7, 1'b0, 196, 1};
        vecs[8] = '{"nramp",        K_NRAMP, 1'b0, 196, 1};

        RSTn = 1'b0; Enable = 1'b0; Row0 = '0; Row1 = '0; Row2 = '0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutputsZero("reset");
        RSTn = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 9; i++) begin
            sendFrame(vecs[i].kind, vecs[i].toggle);
            checkFrame(vecs[i].name, vecs[i].expValid, vecs[i].expFd);
        end

        // Reset in the middle of row 7 while nonzero results are streaming
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                if (!(r == 7 && c > 5)) sendPixel(K_RAMP8, r, c, 1'b0);
        #2;
        RSTn = 1'b0;
        #1;
        checkOutputsZero("midreset");
        sbq.delete();
        validCount = 0;
        fdCount    = 0;
        Enable     = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        idle(3);
        chk("midreset_no_stale_valid", validCount, 0);
        sendFrame(K_VSTEP, 1'b0);
        checkFrame("post_reset", 196, 1);

        // Two frames back-to-back with no gap
        sendFrame(K_HSTEP, 1'b0);
        sendFrame(K_NRAMP, 1'b0);
        checkFrame("back_to_back", 392, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
